// File: rtl/noc_tb_pkg.sv
// Shared helpers for the NoC test-harness delay line.
// The per-lane {valid, data} beat struct is declared inside delay_bank,
// because its data field takes the module's WIDTH parameter and a package
// cannot be parameterised.
package noc_tb_pkg;

   // Force a requested delay into 1..max_delay.
   // A delay of zero would be a combinational path, so it becomes one.
   function automatic int unsigned clamp_delay(input int unsigned req,
                                               input int unsigned max_delay);
      int unsigned res;
      res = req;
      if (res == 0) begin
         res = 1;
      end else if (res > max_delay) begin
         res = max_delay;
      end
      return res;
   endfunction

endpackage

// File: rtl/delay_bank.sv
// One lane of delay storage: a circular buffer of {valid, data} beats.
// The write and read addresses come from the shared pointer in the top module.
// Reads are combinational on a registered address, so a read and a write in
// the same cycle return the old entry. This lets a full-depth delay work.
module delay_bank #(
   parameter int WIDTH     = 32,
   parameter int MAX_DELAY = 8,
   parameter int AW        = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic             flush,
   input  logic [AW-1:0]    waddr,
   input  logic [AW-1:0]    raddr,
   input  logic             wr_valid,
   input  logic [WIDTH-1:0] wr_data,
   output logic             rd_valid,
   output logic [WIDTH-1:0] rd_data
);

   typedef struct packed {
      logic             valid;
      logic [WIDTH-1:0] data;
   } lane_beat_t;

   lane_beat_t mem [MAX_DELAY];

   // Storage update: reset clears everything, flush kills only the valid
   // bits, and a normal write stores the incoming beat, bubbles included.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MAX_DELAY; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         for (int i = 0; i < MAX_DELAY; i++) begin
            mem[i].valid <= 1'b0;
         end
      end else if (we) begin
         mem[waddr] <= '{valid: wr_valid, data: wr_data};
      end
   end

   assign rd_valid = mem[raddr].valid;
   assign rd_data  = mem[raddr].data;

endmodule

// File: rtl/prog_delay_line.sv
// Multi-channel programmable delay line. Every lane shares one write pointer
// and one delay setting. The output is the entry written cur_delay enabled
// edges ago. Stall freezes everything. A config load flushes the storage and
// sets a new delay.
module prog_delay_line
   import noc_tb_pkg::*;
#(
   parameter  int WIDTH         = 32,
   parameter  int CHANNELS      = 1,
   parameter  int MAX_DELAY     = 8,
   parameter  int DEFAULT_DELAY = 1,
   localparam int DW            = $clog2(MAX_DELAY + 1),
   localparam int CW            = $clog2(MAX_DELAY * CHANNELS + 1)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [CHANNELS-1:0]             in_valid,
   input  logic [CHANNELS-1:0][WIDTH-1:0]  in_data,
   input  logic                            stall,
   input  logic                            cfg_we,
   input  logic [DW-1:0]                   cfg_delay,
   output logic [CHANNELS-1:0]             out_valid,
   output logic [CHANNELS-1:0][WIDTH-1:0]  out_data,
   output logic [DW-1:0]                   cur_delay,
   output logic [CW-1:0]                   in_flight
);

   localparam int AW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

   logic [AW-1:0] wp;
   logic [AW-1:0] rd_idx;
   logic [DW:0]   rd_sum;
   logic          advance;
   logic [CW-1:0] in_cnt;
   logic [CW-1:0] out_cnt;

   assign advance = !stall && !cfg_we;

   // Read index is (wp - cur_delay) mod MAX_DELAY. MAX_DELAY is added first
   // so the subtraction never goes negative.
   always_comb begin
      rd_sum = (DW+1)'(wp) + (DW+1)'(MAX_DELAY) - (DW+1)'(cur_delay);
      if (rd_sum >= (DW+1)'(MAX_DELAY)) begin
         rd_sum = rd_sum - (DW+1)'(MAX_DELAY);
      end
      rd_idx = AW'(rd_sum);
   end

   // Count the beats entering this cycle and the beats currently on the
   // output, for the occupancy counter.
   always_comb begin
      in_cnt  = '0;
      out_cnt = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         in_cnt  = in_cnt + CW'(in_valid[i]);
         out_cnt = out_cnt + CW'(out_valid[i]);
      end
   end

   // Shared pointer, active delay and occupancy. A config load wins over
   // stall and restarts the line empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp        <= '0;
         cur_delay <= DW'(DEFAULT_DELAY);
         in_flight <= '0;
      end else if (cfg_we) begin
         wp        <= '0;
         cur_delay <= DW'(clamp_delay(32'(cfg_delay), MAX_DELAY));
         in_flight <= '0;
      end else if (!stall) begin
         wp        <= (wp == AW'(MAX_DELAY - 1)) ? '0 : wp + AW'(1);
         in_flight <= in_flight + in_cnt - out_cnt;
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
      delay_bank #(
         .WIDTH     (WIDTH),
         .MAX_DELAY (MAX_DELAY),
         .AW        (AW)
      ) u_bank (
         .clk      (clk),
         .rst_n    (rst_n),
         .we       (advance),
         .flush    (cfg_we),
         .waddr    (wp),
         .raddr    (rd_idx),
         .wr_valid (in_valid[g]),
         .wr_data  (in_data[g]),
         .rd_valid (out_valid[g]),
         .rd_data  (out_data[g])
      );
   end

endmodule

// File: tb/tb_prog_delay_line.sv
// Self-checking bench for prog_delay_line. The scoreboard stores every
// accepted beat with the enabled-edge count at which it must appear, and
// pops it once it has been presented.
module tb_prog_delay_line;

   localparam int WIDTH     = 16;
   localparam int CHANNELS  = 2;
   localparam int MAX_DELAY = 8;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [1:0]            in_valid;
   logic [1:0][15:0]      in_data;
   logic                  stall;
   logic                  cfg_we;
   logic [3:0]            cfg_delay;
   logic [1:0]            out_valid;
   logic [1:0][15:0]      out_data;
   logic [3:0]            cur_delay;
   logic [4:0]            in_flight;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] data;
      int          due;
   } sb_t;

   sb_t sbq [2][$];
   int  tick    = 0;
   int  m_delay = 1;

   always #5 clk = ~clk;

   prog_delay_line #(
      .WIDTH         (WIDTH),
      .CHANNELS      (CHANNELS),
      .MAX_DELAY     (MAX_DELAY),
      .DEFAULT_DELAY (1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .stall     (stall),
      .cfg_we    (cfg_we),
      .cfg_delay (cfg_delay),
      .out_valid (out_valid),
      .out_data  (out_data),
      .cur_delay (cur_delay),
      .in_flight (in_flight)
   );

   // Drive one cycle starting at a falling edge, update the scoreboard at the
   // rising edge, and return at the next falling edge.
   task automatic drive_cycle(input logic [1:0] v, input logic [15:0] d0,
                              input logic [15:0] d1, input logic st,
                              input logic cw, input logic [3:0] cd);
      in_valid   = v;
      in_data[0] = d0;
      in_data[1] = d1;
      stall      = st;
      cfg_we     = cw;
      cfg_delay  = cd;
      @(posedge clk);
      if (cw) begin
         sbq[0].delete();
         sbq[1].delete();
         m_delay = (cd == 4'd0) ? 1 : ((int'(cd) > MAX_DELAY) ? MAX_DELAY : int'(cd));
      end else if (!st) begin
         for (int l = 0; l < 2; l++) begin
            if (sbq[l].size() > 0 && sbq[l][0].due == tick) begin
               void'(sbq[l].pop_front());
            end
            if (v[l]) begin
               sbq[l].push_back('{data: (l == 0) ? d0 : d1, due: tick + m_delay});
            end
         end
         tick++;
      end
      @(negedge clk);
      in_valid = 2'b00;
      stall    = 1'b0;
      cfg_we   = 1'b0;
   endtask

   task automatic drive_idle();
      drive_cycle(2'b00, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 4'd0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid   = 2'($urandom);
         in_data[0] = 16'($urandom);
         in_data[1] = 16'($urandom);
         stall      = 1'($urandom);
         cfg_we     = 1'($urandom);
         cfg_delay  = 4'($urandom);
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (out_valid !== 2'b00 || out_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_out: got valid %b data %h, expected 0 and 0", out_valid, out_data);
         end
         checks++;
         if (cur_delay !== 4'd1 || in_flight !== 5'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: got cur_delay %0d in_flight %0d, expected 1 and 0", cur_delay, in_flight);
         end
      end
      in_valid = 2'b00;
      stall    = 1'b0;
      cfg_we   = 1'b0;
      rst_n    = 1'b1;
   endtask

   task automatic test_delay3();
      int   seen0 = -1;
      int   seen1 = -1;
      int   exp_if [5] = '{1, 2, 2, 1, 0};
      logic exp_v;
      drive_cycle(2'b00, 16'h0, 16'h0, 1'b0, 1'b1, 4'd3);
      checks++;
      if (cur_delay !== 4'd3) begin
         errors++;
         $display("[TB] FAIL delay3_cfg: got %0d, expected 3", cur_delay);
      end
      for (int n = 1; n <= 7; n++) begin
         if (n == 1)      drive_cycle(2'b01, 16'h00A5, 16'h1111, 1'b0, 1'b0, 4'd0);
         else if (n == 2) drive_cycle(2'b10, 16'h2222, 16'h005A, 1'b0, 1'b0, 4'd0);
         else             drive_idle();
         for (int l = 0; l < 2; l++) begin
            exp_v = (sbq[l].size() > 0) && (sbq[l][0].due == tick);
            checks++;
            if (out_valid[l] !== exp_v) begin
               errors++;
               $display("[TB] FAIL delay3_valid lane%0d cycle %0d: got %b, expected %b", l, n, out_valid[l], exp_v);
            end
            if (exp_v) begin
               checks++;
               if (out_data[l] !== sbq[l][0].data) begin
                  errors++;
                  $display("[TB] FAIL delay3_data lane%0d: got %h, expected %h", l, out_data[l], sbq[l][0].data);
               end
            end
         end
         checks++;
         if (in_flight !== 5'(sbq[0].size() + sbq[1].size())) begin
            errors++;
            $display("[TB] FAIL delay3_inflight_sb: got %0d, expected %0d", in_flight, sbq[0].size() + sbq[1].size());
         end
         if (n <= 5) begin
            checks++;
            if (in_flight !== 5'(exp_if[n-1])) begin
               errors++;
               $display("[TB] FAIL delay3_inflight cycle %0d: got %0d, expected %0d", n, in_flight, exp_if[n-1]);
            end
         end
         if (out_valid[0] === 1'b1 && seen0 < 0) seen0 = n;
         if (out_valid[1] === 1'b1 && seen1 < 0) seen1 = n;
      end
      checks++;
      if (seen0 != 3 || seen1 != 4) begin
         errors++;
         $display("[TB] FAIL delay3_latency: got lane0 %0d lane1 %0d, expected 3 and 4", seen0, seen1);
      end
   endtask

   task automatic test_clamp_wrap();
      int   first = -1;
      int   last  = -1;
      int   next0 = 0;
      logic exp_v;
      drive_cycle(2'b00, 16'h0, 16'h0, 1'b0, 1'b1, 4'd0);
      checks++;
      if (cur_delay !== 4'd1) begin
         errors++;
         $display("[TB] FAIL clamp_zero: got %0d, expected 1", cur_delay);
      end
      drive_cycle(2'b00, 16'h0, 16'h0, 1'b0, 1'b1, 4'd12);
      checks++;
      if (cur_delay !== 4'd8) begin
         errors++;
         $display("[TB] FAIL clamp_high: got %0d, expected 8", cur_delay);
      end
      for (int n = 1; n <= 34; n++) begin
         if (n <= 20) drive_cycle(2'b11, 16'(n - 1), 16'h0100 + 16'(n - 1), 1'b0, 1'b0, 4'd0);
         else         drive_idle();
         for (int l = 0; l < 2; l++) begin
            exp_v = (sbq[l].size() > 0) && (sbq[l][0].due == tick);
            checks++;
            if (out_valid[l] !== exp_v) begin
               errors++;
               $display("[TB] FAIL wrap_valid lane%0d cycle %0d: got %b, expected %b", l, n, out_valid[l], exp_v);
            end
            if (exp_v) begin
               checks++;
               if (out_data[l] !== sbq[l][0].data) begin
                  errors++;
                  $display("[TB] FAIL wrap_data lane%0d: got %h, expected %h", l, out_data[l], sbq[l][0].data);
               end
            end
         end
         checks++;
         if (in_flight !== 5'(sbq[0].size() + sbq[1].size())) begin
            errors++;
            $display("[TB] FAIL wrap_inflight: got %0d, expected %0d", in_flight, sbq[0].size() + sbq[1].size());
         end
         if (out_valid[0] === 1'b1) begin
            if (first < 0) first = n;
            last = n;
            checks++;
            if (out_data[0] !== 16'(next0)) begin
               errors++;
               $display("[TB] FAIL wrap_order: got %h, expected %h", out_data[0], 16'(next0));
            end
            next0++;
         end
      end
      checks++;
      if (first != 8 || last != 27 || next0 != 20) begin
         errors++;
         $display("[TB] FAIL wrap_stream: got first %0d last %0d count %0d, expected 8 27 20", first, last, next0);
      end
   endtask

   task automatic test_stall();
      int   emerge = -1;
      logic exp_v;
      drive_cycle(2'b00, 16'h0, 16'h0, 1'b0, 1'b1, 4'd4);
      for (int n = 1; n <= 16; n++) begin
         if (n == 1)
            drive_cycle(2'b01, 16'h0011, 16'h0, 1'b0, 1'b0, 4'd0);
         else if ((n >= 2 && n <= 4) || n == 8 || n == 9)
            drive_cycle(2'b11, 16'hEEEE, 16'hEEEE, 1'b1, 1'b0, 4'd0);
         else
            drive_idle();
         for (int l = 0; l < 2; l++) begin
            exp_v = (sbq[l].size() > 0) && (sbq[l][0].due == tick);
            checks++;
            if (out_valid[l] !== exp_v) begin
               errors++;
               $display("[TB] FAIL stall_valid lane%0d cycle %0d: got %b, expected %b", l, n, out_valid[l], exp_v);
            end
            if (exp_v) begin
               checks++;
               if (out_data[l] !== sbq[l][0].data) begin
                  errors++;
                  $display("[TB] FAIL stall_data lane%0d: got %h, expected %h", l, out_data[l], sbq[l][0].data);
               end
            end
         end
         checks++;
         if (in_flight !== 5'(sbq[0].size() + sbq[1].size())) begin
            errors++;
            $display("[TB] FAIL stall_inflight: got %0d, expected %0d", in_flight, sbq[0].size() + sbq[1].size());
         end
         if (n == 8 || n == 9) begin
            checks++;
            if (out_valid[0] !== 1'b1 || out_data[0] !== 16'h0011) begin
               errors++;
               $display("[TB] FAIL stall_hold cycle %0d: got %b/%h, expected 1/0011", n, out_valid[0], out_data[0]);
            end
         end
         if (out_valid[0] === 1'b1 && emerge < 0) emerge = n;
      end
      checks++;
      if (emerge != 7) begin
         errors++;
         $display("[TB] FAIL stall_latency: got %0d, expected 7", emerge);
      end
   endtask

   task automatic test_flush();
      int   emerge = -1;
      int   stale  = 0;
      logic exp_v;
      drive_cycle(2'b00, 16'h0, 16'h0, 1'b0, 1'b1, 4'd5);
      drive_cycle(2'b01, 16'h00B1, 16'h0, 1'b0, 1'b0, 4'd0);
      drive_cycle(2'b10, 16'h0, 16'h00B2, 1'b0, 1'b0, 4'd0);
      drive_cycle(2'b01, 16'h00B3, 16'h0, 1'b0, 1'b0, 4'd0);
      checks++;
      if (in_flight !== 5'd3) begin
         errors++;
         $display("[TB] FAIL flush_pre: got in_flight %0d, expected 3", in_flight);
      end
      drive_cycle(2'b11, 16'hCCCC, 16'hCCCC, 1'b1, 1'b1, 4'd2);
      checks++;
      if (in_flight !== 5'd0 || cur_delay !== 4'd2) begin
         errors++;
         $display("[TB] FAIL flush_state: got in_flight %0d cur_delay %0d, expected 0 and 2", in_flight, cur_delay);
      end
      for (int n = 1; n <= 12; n++) begin
         if (n == 1) drive_cycle(2'b10, 16'h0, 16'h0077, 1'b0, 1'b0, 4'd0);
         else        drive_idle();
         for (int l = 0; l < 2; l++) begin
            exp_v = (sbq[l].size() > 0) && (sbq[l][0].due == tick);
            checks++;
            if (out_valid[l] !== exp_v) begin
               errors++;
               $display("[TB] FAIL flush_valid lane%0d cycle %0d: got %b, expected %b", l, n, out_valid[l], exp_v);
            end
            if (exp_v) begin
               checks++;
               if (out_data[l] !== sbq[l][0].data) begin
                  errors++;
                  $display("[TB] FAIL flush_data lane%0d: got %h, expected %h", l, out_data[l], sbq[l][0].data);
               end
            end
         end
         checks++;
         if (in_flight !== 5'(sbq[0].size() + sbq[1].size())) begin
            errors++;
            $display("[TB] FAIL flush_inflight: got %0d, expected %0d", in_flight, sbq[0].size() + sbq[1].size());
         end
         if (out_valid[0] === 1'b1) stale++;
         if (out_valid[1] === 1'b1 && emerge < 0) emerge = n;
      end
      checks++;
      if (emerge != 2 || stale != 0) begin
         errors++;
         $display("[TB] FAIL flush_result: got emerge %0d stale %0d, expected 2 and 0", emerge, stale);
      end
   endtask

   task automatic test_async_reset();
      int   late = 0;
      logic exp_v;
      drive_cycle(2'b00, 16'h0, 16'h0, 1'b0, 1'b1, 4'd3);
      drive_cycle(2'b11, 16'h0D01, 16'h0D02, 1'b0, 1'b0, 4'd0);
      drive_cycle(2'b11, 16'h0D03, 16'h0D04, 1'b0, 1'b0, 4'd0);
      drive_idle();
      checks++;
      if (in_flight !== 5'd4 || out_valid !== 2'b11) begin
         errors++;
         $display("[TB] FAIL areset_pre: got in_flight %0d valid %b, expected 4 and 11", in_flight, out_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 2'b00 || out_data !== 32'h0) begin
         errors++;
         $display("[TB] FAIL areset_out: got valid %b data %h, expected 0 and 0", out_valid, out_data);
      end
      checks++;
      if (in_flight !== 5'd0 || cur_delay !== 4'd1) begin
         errors++;
         $display("[TB] FAIL areset_state: got in_flight %0d cur_delay %0d, expected 0 and 1", in_flight, cur_delay);
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      sbq[0].delete();
      sbq[1].delete();
      m_delay = 1;
      for (int n = 1; n <= 8; n++) begin
         drive_idle();
         for (int l = 0; l < 2; l++) begin
            exp_v = (sbq[l].size() > 0) && (sbq[l][0].due == tick);
            checks++;
            if (out_valid[l] !== exp_v) begin
               errors++;
               $display("[TB] FAIL areset_valid lane%0d cycle %0d: got %b, expected %b", l, n, out_valid[l], exp_v);
            end
         end
         if (out_valid !== 2'b00) late++;
      end
      checks++;
      if (late != 0 || in_flight !== 5'd0) begin
         errors++;
         $display("[TB] FAIL areset_after: got late %0d in_flight %0d, expected 0 and 0", late, in_flight);
      end
   endtask

   initial begin
      in_valid  = 2'b00;
      in_data   = '0;
      stall     = 1'b0;
      cfg_we    = 1'b0;
      cfg_delay = 4'd0;
      test_reset();
      test_delay3();
      test_clamp_wrap();
      test_stall();
      test_flush();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] timeout");
   end

endmodule
